// File: rtl/mano_ctrl_pkg.sv
// Shared types and encodings for the basic-computer AC/E instruction sequencer.
package mano_ctrl_pkg;

  localparam int W = 16;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    INDIR,
    READ,
    EXEC,
    HALT,
    RRSEQ
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_RR  = 3'b111;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_DR  = 3'd2;
  localparam logic [2:0] ALU_CMA = 3'd3;
  localparam logic [2:0] ALU_SHR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;

  typedef struct packed {
    logic       mem_rd;
    logic       ar_ld;
    logic       dr_ld;
    logic       ac_ld;
    logic       ac_inr;
    logic       ac_clr;
    logic [2:0] alu_sel;
    logic       e_ld;
    logic       e_clr;
    logic       e_cmp;
  } strobe_t;

  function automatic logic is_mem_ref(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mano_ac_ctrl_if.sv
// Instruction handshake and AC/E/memory control bus of the AC sequencer.
interface mano_ac_ctrl_if #(
  parameter int W = 16
);

  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] ir;
  logic         ac_zero;
  logic         ac_sign;
  logic         e_in;
  logic         mem_rd;
  logic         ar_ld;
  logic         dr_ld;
  logic         ac_ld;
  logic         ac_inr;
  logic         ac_clr;
  logic [2:0]   alu_sel;
  logic         e_ld;
  logic         e_clr;
  logic         e_cmp;
  logic         skip;
  logic         done;
  logic         unsup;
  logic         halted;

  modport master (
    output instr_valid, ir, ac_zero, ac_sign, e_in,
    input  instr_ready, mem_rd, ar_ld, dr_ld, ac_ld, ac_inr, ac_clr,
           alu_sel, e_ld, e_clr, e_cmp, skip, done, unsup, halted
  );

  modport slave (
    input  instr_valid, ir, ac_zero, ac_sign, e_in,
    output instr_ready, mem_rd, ar_ld, dr_ld, ac_ld, ac_inr, ac_clr,
           alu_sel, e_ld, e_clr, e_cmp, skip, done, unsup, halted
  );

endinterface

// File: rtl/mano_rr_decode.sv
// Register-reference decode: picks the highest set bit of rr_bits and produces
// its strobes, its skip condition and the remaining (unexecuted) bits.
module mano_rr_decode
  import mano_ctrl_pkg::*;
(
  input  logic [11:0] rr_bits,
  input  logic        ac_sign,
  input  logic        ac_zero,
  input  logic        e_in,
  output strobe_t     strobe,
  output logic        skip_cond,
  output logic        hlt,
  output logic [11:0] rr_rest
);

  logic [3:0] sel_idx;
  logic       any;

  // Upward scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    sel_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rr_bits[i]) begin
        sel_idx = 4'(i);
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    strobe    = '0;
    skip_cond = 1'b0;
    hlt       = 1'b0;
    rr_rest   = rr_bits;
    if (any) begin
      rr_rest[sel_idx] = 1'b0;
      case (sel_idx)
        4'(RR_CLA): strobe.ac_clr = 1'b1;
        4'(RR_CLE): strobe.e_clr  = 1'b1;
        4'(RR_CMA): begin
          strobe.ac_ld   = 1'b1;
          strobe.alu_sel = ALU_CMA;
        end
        4'(RR_CME): strobe.e_cmp  = 1'b1;
        4'(RR_CIR): begin
          strobe.ac_ld   = 1'b1;
          strobe.e_ld    = 1'b1;
          strobe.alu_sel = ALU_SHR;
        end
        4'(RR_CIL): begin
          strobe.ac_ld   = 1'b1;
          strobe.e_ld    = 1'b1;
          strobe.alu_sel = ALU_SHL;
        end
        4'(RR_INC): strobe.ac_inr = 1'b1;
        4'(RR_SPA): skip_cond = !ac_sign;
        4'(RR_SNA): skip_cond = ac_sign;
        4'(RR_SZA): skip_cond = ac_zero;
        4'(RR_SZE): skip_cond = !e_in;
        4'(RR_HLT): hlt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mano_ac_ctrl.sv
// Basic-computer AC/E instruction sequencer (indirect, read, execute steps).
// Define MULTI_RR_EN to execute every set register-reference bit, one per cycle.
module mano_ac_ctrl
  import mano_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic          CLK,
  input  logic          CLR_N,
  mano_ac_ctrl_if.slave bus
);

  state_t       state, state_nx;
  logic [W-1:0] ir_q;
  logic         halted_q, halted_nx;
  logic         accept;
  logic         rr_step;
  logic         ready, done, unsup, skip;
  strobe_t      str, rr_str;
  logic         rr_skip, rr_hlt;
  logic [11:0]  rr_bits, rr_rest;
  logic [2:0]   op;
  logic         ind;

`ifdef MULTI_RR_EN
  logic [11:0] rr_rem, rr_rem_nx;
  logic        skip_acc, skip_acc_nx;

  assign rr_bits = (state == DECODE) ? ir_q[11:0] : rr_rem;
`else
  assign rr_bits = ir_q[11:0];
`endif

  assign op     = ir_q[14:12];
  assign ind    = ir_q[15];
  assign accept = (state == IDLE) && !halted_q && bus.instr_valid;

  mano_rr_decode u_rr_decode (
    .rr_bits   (rr_bits),
    .ac_sign   (bus.ac_sign),
    .ac_zero   (bus.ac_zero),
    .e_in      (bus.e_in),
    .strobe    (rr_str),
    .skip_cond (rr_skip),
    .hlt       (rr_hlt),
    .rr_rest   (rr_rest)
  );

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state    <= IDLE;
      ir_q     <= '0;
      halted_q <= 1'b0;
`ifdef MULTI_RR_EN
      rr_rem   <= '0;
      skip_acc <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      halted_q <= halted_nx;
      if (accept) begin
        ir_q <= bus.ir;
      end
`ifdef MULTI_RR_EN
      rr_rem   <= rr_rem_nx;
      skip_acc <= skip_acc_nx;
`endif
    end
  end

  // Strobes are decoded from the current state only, so an asserted CLR_N
  // silences them in the same instant the state register clears.
  always_comb begin
    state_nx  = state;
    halted_nx = halted_q;
    str       = '0;
    ready     = 1'b0;
    done      = 1'b0;
    unsup     = 1'b0;
    skip      = 1'b0;
    rr_step   = 1'b0;
`ifdef MULTI_RR_EN
    rr_rem_nx   = rr_rem;
    skip_acc_nx = skip_acc;
`endif
    case (state)
      IDLE: begin
        ready = !halted_q;
        if (accept) begin
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (!ind && (op == OP_RR)) begin
          rr_step = 1'b1;
        end else if (is_mem_ref(op)) begin
          state_nx = ind ? INDIR : READ;
        end else begin
          done     = 1'b1;
          unsup    = 1'b1;
          state_nx = IDLE;
        end
      end
      RRSEQ: rr_step = 1'b1;
      INDIR: begin
        str.mem_rd = 1'b1;
        str.ar_ld  = 1'b1;
        state_nx   = READ;
      end
      READ: begin
        str.mem_rd = 1'b1;
        str.dr_ld  = 1'b1;
        state_nx   = EXEC;
      end
      EXEC: begin
        str.ac_ld = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
        case (op)
          OP_ADD: begin
            str.e_ld    = 1'b1;
            str.alu_sel = ALU_ADD;
          end
          OP_LDA:  str.alu_sel = ALU_DR;
          default: str.alu_sel = ALU_AND;
        endcase
      end
      HALT: ;
      default: state_nx = IDLE;
    endcase

    if (rr_step) begin
      str = rr_str;
`ifdef MULTI_RR_EN
      if (rr_rest != '0) begin
        rr_rem_nx   = rr_rest;
        skip_acc_nx = skip_acc | rr_skip;
        state_nx    = RRSEQ;
      end else begin
        done        = 1'b1;
        skip        = skip_acc | rr_skip;
        skip_acc_nx = 1'b0;
        halted_nx   = halted_q | rr_hlt;
        state_nx    = rr_hlt ? HALT : IDLE;
      end
`else
      done      = 1'b1;
      skip      = rr_skip;
      halted_nx = halted_q | rr_hlt;
      state_nx  = rr_hlt ? HALT : IDLE;
`endif
    end
  end

  assign bus.instr_ready = ready;
  assign bus.mem_rd      = str.mem_rd;
  assign bus.ar_ld       = str.ar_ld;
  assign bus.dr_ld       = str.dr_ld;
  assign bus.ac_ld       = str.ac_ld;
  assign bus.ac_inr      = str.ac_inr;
  assign bus.ac_clr      = str.ac_clr;
  assign bus.alu_sel     = str.alu_sel;
  assign bus.e_ld        = str.e_ld;
  assign bus.e_clr       = str.e_clr;
  assign bus.e_cmp       = str.e_cmp;
  assign bus.skip        = skip;
  assign bus.done        = done;
  assign bus.unsup       = unsup;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_mano_ac_ctrl.sv
// Self-checking bench for mano_ac_ctrl: fixed vectors, hand sequences and
// random instructions against a per-instruction cycle-list model.
module tb_mano_ac_ctrl;

  logic CLK   = 1'b0;
  logic CLR_N = 1'b1;

  mano_ac_ctrl_if #(.W(16)) bus ();

  mano_ac_ctrl #(.W(16)) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [16:0] O_RDY   = 17'd1 << 16;
  localparam logic [16:0] O_MRD   = 17'd1 << 15;
  localparam logic [16:0] O_ARLD  = 17'd1 << 14;
  localparam logic [16:0] O_DRLD  = 17'd1 << 13;
  localparam logic [16:0] O_ACLD  = 17'd1 << 12;
  localparam logic [16:0] O_ACINR = 17'd1 << 11;
  localparam logic [16:0] O_ACCLR = 17'd1 << 10;
  localparam logic [16:0] O_ELD   = 17'd1 << 6;
  localparam logic [16:0] O_ECLR  = 17'd1 << 5;
  localparam logic [16:0] O_ECMP  = 17'd1 << 4;
  localparam logic [16:0] O_SKIP  = 17'd1 << 3;
  localparam logic [16:0] O_DONE  = 17'd1 << 2;
  localparam logic [16:0] O_UNSUP = 17'd1 << 1;
  localparam logic [16:0] O_HLTD  = 17'd1;
  localparam logic [16:0] ALL     = '1;

  typedef struct {
    string       name;
    logic [15:0] w;
    logic        z;
    logic        s;
    logic        e;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] exp_q[$];
  bit          halt_exp;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [16:0] alu(input int n);
    return 17'(n) << 7;
  endfunction

  function automatic logic [16:0] sampleOut();
    return {bus.instr_ready, bus.mem_rd, bus.ar_ld, bus.dr_ld, bus.ac_ld,
            bus.ac_inr, bus.ac_clr, bus.alu_sel, bus.e_ld, bus.e_clr,
            bus.e_cmp, bus.skip, bus.done, bus.unsup, bus.halted};
  endfunction

  function automatic void addVec(input string name, input logic [15:0] w,
                                 input logic z, input logic s, input logic e,
                                 input logic [16:0] exp);
    vec_t v;
    v.name = name;
    v.w    = w;
    v.z    = z;
    v.s    = s;
    v.e    = e;
    v.exp  = exp;
    tbl.push_back(v);
  endfunction

  // Register-reference bit effects, indexed by bit position (skip handled apart).
  function automatic logic [16:0] rrEffect(input int b);
    case (b)
      11:      return O_ACCLR;
      10:      return O_ECLR;
      9:       return O_ACLD | alu(3);
      8:       return O_ECMP;
      7:       return O_ACLD | O_ELD | alu(4);
      6:       return O_ACLD | O_ELD | alu(5);
      5:       return O_ACINR;
      default: return 17'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] exp,
                             input logic [16:0] care);
    logic [16:0] act;
    act = sampleOut();
    checks++;
    if ((act & care) !== (exp & care)) begin
      errors++;
      $display("[TB] FAIL %s: got %05h expected %05h (care %05h)", name, act, exp, care);
    end
  endtask

  // Expected per-cycle outputs of one instruction, starting at the cycle after accept.
  task automatic buildModel(input logic [15:0] w, input logic z, input logic s,
                            input logic e);
    int          chosen[$];
    bit          acc;
    logic [16:0] v;
    exp_q.delete();
    halt_exp = 1'b0;
    if (w[15:12] == 4'h7) begin
      for (int b = 11; b >= 0; b--) begin
        if (w[b]) chosen.push_back(b);
      end
`ifndef MULTI_RR_EN
      while (chosen.size() > 1) void'(chosen.pop_back());
`endif
      if (chosen.size() == 0) exp_q.push_back(O_DONE);
      acc = 1'b0;
      foreach (chosen[k]) begin
        v = rrEffect(chosen[k]);
        case (chosen[k])
          4: acc = acc | !s;
          3: acc = acc | s;
          2: acc = acc | z;
          1: acc = acc | !e;
          0: halt_exp = 1'b1;
          default: ;
        endcase
        if (k == chosen.size() - 1) v = v | O_DONE | (acc ? O_SKIP : 17'd0);
        exp_q.push_back(v);
      end
    end else if (w[14:12] <= 3'd2) begin
      exp_q.push_back(17'd0);
      if (w[15]) exp_q.push_back(O_MRD | O_ARLD);
      exp_q.push_back(O_MRD | O_DRLD);
      case (w[14:12])
        3'd0:    exp_q.push_back(O_ACLD | alu(0) | O_DONE);
        3'd1:    exp_q.push_back(O_ACLD | O_ELD | alu(1) | O_DONE);
        default: exp_q.push_back(O_ACLD | alu(2) | O_DONE);
      endcase
    end else begin
      exp_q.push_back(O_DONE | O_UNSUP);
    end
  endtask

  task automatic offer(input string name, input logic [15:0] w, input logic z,
                       input logic s, input logic e);
    @(negedge CLK);
    bus.ir          = w;
    bus.ac_zero     = z;
    bus.ac_sign     = s;
    bus.e_in        = e;
    bus.instr_valid = 1'b1;
    #1 checkOutput({name, " idle"}, O_RDY, ALL);
  endtask

  task automatic stepCheck(input string name, input logic [16:0] exp);
    @(negedge CLK);
    bus.instr_valid = 1'b0;
    #1 checkOutput(name, exp, ALL);
  endtask

  task automatic doReset();
    @(negedge CLK);
    bus.instr_valid = 1'b0;
    CLR_N = 1'b0;
    #1 checkOutput("reset strobes", 17'd0, ~O_RDY);
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    #1 checkOutput("after reset", O_RDY, ALL);
  endtask

  // Busy cycles carry junk on instr_valid/ir, which the DUT must ignore.
  task automatic applyStimulus(input string name, input logic [15:0] w,
                               input logic z, input logic s, input logic e);
    buildModel(w, z, s, e);
    offer(name, w, z, s, e);
    foreach (exp_q[k]) begin
      @(negedge CLK);
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.ir          = 16'($urandom);
      #1 checkOutput($sformatf("%s %04h cyc%0d", name, w, k + 1), exp_q[k], ALL);
    end
    if (halt_exp) begin
      @(negedge CLK);
      bus.instr_valid = 1'b1;
      #1 checkOutput("halted hold", O_HLTD, ALL);
      @(negedge CLK);
      #1 checkOutput("halted hold2", O_HLTD, ALL);
      doReset();
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] r1, r2;

    bus.instr_valid = 1'b0;
    bus.ir          = '0;
    bus.ac_zero     = 1'b0;
    bus.ac_sign     = 1'b0;
    bus.e_in        = 1'b0;

    #1 CLR_N = 1'b0;
    #2 checkOutput("reset state", 17'd0, ~O_RDY);
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    #1 checkOutput("ready after reset", O_RDY, ALL);

    addVec("CLA",     16'h7800, 1'b0, 1'b0, 1'b0, O_ACCLR | O_DONE);
    addVec("CLE",     16'h7400, 1'b0, 1'b0, 1'b0, O_ECLR | O_DONE);
    addVec("CMA",     16'h7200, 1'b0, 1'b0, 1'b0, O_ACLD | alu(3) | O_DONE);
    addVec("CME",     16'h7100, 1'b0, 1'b0, 1'b0, O_ECMP | O_DONE);
    addVec("CIR",     16'h7080, 1'b0, 1'b0, 1'b0, O_ACLD | O_ELD | alu(4) | O_DONE);
    addVec("CIL",     16'h7040, 1'b0, 1'b0, 1'b0, O_ACLD | O_ELD | alu(5) | O_DONE);
    addVec("INC",     16'h7020, 1'b0, 1'b0, 1'b0, O_ACINR | O_DONE);
    addVec("SPA pos", 16'h7010, 1'b0, 1'b0, 1'b0, O_SKIP | O_DONE);
    addVec("SPA neg", 16'h7010, 1'b0, 1'b1, 1'b0, O_DONE);
    addVec("SNA neg", 16'h7008, 1'b0, 1'b1, 1'b0, O_SKIP | O_DONE);
    addVec("SNA pos", 16'h7008, 1'b0, 1'b0, 1'b0, O_DONE);
    addVec("SZA z1",  16'h7004, 1'b1, 1'b0, 1'b0, O_SKIP | O_DONE);
    addVec("SZA z0",  16'h7004, 1'b0, 1'b0, 1'b0, O_DONE);
    addVec("SZE e0",  16'h7002, 1'b0, 1'b0, 1'b0, O_SKIP | O_DONE);
    addVec("SZE e1",  16'h7002, 1'b0, 1'b0, 1'b1, O_DONE);
    addVec("RR none", 16'h7000, 1'b0, 1'b0, 1'b0, O_DONE);
    addVec("STA",     16'h3123, 1'b0, 1'b0, 1'b0, O_DONE | O_UNSUP);
    addVec("BUN",     16'h4000, 1'b0, 1'b0, 1'b0, O_DONE | O_UNSUP);
    addVec("I op7",   16'hF800, 1'b0, 1'b0, 1'b0, O_DONE | O_UNSUP);
`ifndef MULTI_RR_EN
    addVec("CLA>INC", 16'h7820, 1'b0, 1'b0, 1'b0, O_ACCLR | O_DONE);
    addVec("SZE>HLT", 16'h7003, 1'b0, 1'b0, 1'b0, O_SKIP | O_DONE);
`endif

    foreach (tbl[i]) begin
      offer(tbl[i].name, tbl[i].w, tbl[i].z, tbl[i].s, tbl[i].e);
      stepCheck(tbl[i].name, tbl[i].exp);
    end

    offer("ADD dir", 16'h1123, 1'b0, 1'b0, 1'b0);
    stepCheck("ADD decode", 17'd0);
    stepCheck("ADD read", O_MRD | O_DRLD);
    stepCheck("ADD exec", O_ACLD | O_ELD | alu(1) | O_DONE);

    offer("LDA ind", 16'hA123, 1'b0, 1'b0, 1'b0);
    stepCheck("LDA decode", 17'd0);
    stepCheck("LDA indir", O_MRD | O_ARLD);
    stepCheck("LDA read", O_MRD | O_DRLD);
    stepCheck("LDA exec", O_ACLD | alu(2) | O_DONE);

    offer("HLT", 16'h7001, 1'b0, 1'b0, 1'b0);
    stepCheck("HLT decode", O_DONE);
    @(negedge CLK);
    bus.instr_valid = 1'b1;
    #1 checkOutput("HLT halted", O_HLTD, ALL);
    @(negedge CLK);
    #1 checkOutput("HLT ignores valid", O_HLTD, ALL);
    doReset();

    offer("ADD abort", 16'h1123, 1'b0, 1'b0, 1'b0);
    stepCheck("abort decode", 17'd0);
    stepCheck("abort read", O_MRD | O_DRLD);
    #2 CLR_N = 1'b0;
    #1 checkOutput("abort strobes", 17'd0, ~O_RDY);
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    #1 checkOutput("abort recovered", O_RDY, ALL);

`ifdef MULTI_RR_EN
    offer("CMA+INC", 16'h7220, 1'b0, 1'b0, 1'b0);
    stepCheck("CMA+INC c1", O_ACLD | alu(3));
    stepCheck("CMA+INC c2", O_ACINR | O_DONE);
`endif

    for (int n = 0; n < 200; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 3))
        0:       w = {4'h7, 12'd1 << $urandom_range(0, 11)};
        1:       w = {4'h7, r1[11:0] & r2[11:0]};
        2:       w = {r1[15], 3'($urandom_range(0, 2)), r1[11:0]};
        default: w = r1[15:0];
      endcase
      applyStimulus("rand", w, r2[20], r2[21], r2[22]);
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
